// File: rtl/dec_unbinder_seq_pkg.sv
// Shared HDC decode package: hypervector geometry, per-feature bind shifts and
// the unbinder FSM state type.
package dec_unbinder_seq_pkg;

    localparam int unsigned HV_DIM          = 1024;
    localparam int unsigned FEATURES_PER_CC = 8;
    localparam int unsigned NUM_SHIFTS      = 320;

    // Bind shift table shared with the encoder; entries are reduced mod HV_DIM by users.
    localparam int unsigned SHIFTS [NUM_SHIFTS] = '{
        310: 3, 311: 0, 312: 15, 313: 8, 314: 517, 315: 1023, 316: 64, 317: 1361,
        default: 1
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } dec_unbind_state_t;

endpackage

// File: rtl/hv_rotr.sv
// Combinational circular rotate-right of a hypervector by a dynamic amount:
// data_o[j] = data_i[(j + amt_i) mod Width]. amt_i must be below Width.
module hv_rotr #(
    parameter int unsigned Width = 1024,
    localparam int unsigned AmtW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] data_i,
    input  logic [AmtW-1:0]  amt_i,
    output logic [Width-1:0] data_o
);

    // Shifting the doubled vector right wraps the low bits back in from the top copy.
    always_comb begin
        data_o = Width'({data_i, data_i} >> amt_i);
    end

endmodule

// File: rtl/dec_unbinder_seq.sv
// Sequential unbinder: captures a bank of bound hypervectors and streams out the
// recovered level HVs one per handshake through a single shared rotator.
// Optional feature macro: DEC_UNBIND_POPCOUNT_EN adds hv_weight (popcount of level_hv).
module dec_unbinder_seq #(
    parameter int unsigned HV_DIM          = dec_unbinder_seq_pkg::HV_DIM,
    parameter int unsigned FEATURES_PER_CC = dec_unbinder_seq_pkg::FEATURES_PER_CC,
    parameter int unsigned SHIFT_BASE      = 310
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start_decoding,
    input  logic [HV_DIM-1:0]                  shifted_hv [0:FEATURES_PER_CC-1],
    output logic [HV_DIM-1:0]                  level_hv,
    output logic [$clog2(FEATURES_PER_CC)-1:0] feat_idx,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
`ifdef DEC_UNBIND_POPCOUNT_EN
    output logic [$clog2(HV_DIM+1)-1:0]        hv_weight,
`endif
    output logic                               done
);

    import dec_unbinder_seq_pkg::*;

    localparam int unsigned AmtW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
    localparam int unsigned CntW = $clog2(FEATURES_PER_CC);
    localparam logic [CntW-1:0] LastIdx = CntW'(FEATURES_PER_CC - 1);

    dec_unbind_state_t state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [HV_DIM-1:0] bank_q [FEATURES_PER_CC];
    logic [HV_DIM-1:0] level_q, level_d;
    logic [CntW-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              load_bank;
    logic              level_load;
    logic [CntW-1:0]   rot_idx;
    logic [HV_DIM-1:0] rot_out;

    // Rotation amounts are constants fixed at elaboration.
    logic [AmtW-1:0] rot_amt [FEATURES_PER_CC];
    for (genvar i = 0; i < FEATURES_PER_CC; i++) begin : g_amt
        assign rot_amt[i] = AmtW'(SHIFTS[SHIFT_BASE + i] % HV_DIM);
    end

    // In RUN the rotator looks one feature ahead so the next HV loads on the handshake edge.
    always_comb begin
        rot_idx = cnt_q;
        if (state_q == RUN && cnt_q != LastIdx) begin
            rot_idx = cnt_q + 1'b1;
        end
    end

    hv_rotr #(
        .Width (HV_DIM)
    ) u_rotr (
        .data_i (bank_q[rot_idx]),
        .amt_i  (rot_amt[rot_idx]),
        .data_o (rot_out)
    );

    // Next-state and datapath load decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        load_bank  = 1'b0;
        level_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_decoding) begin
                    load_bank = 1'b1;
                    cnt_d     = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                level_d    = rot_out;
                level_load = 1'b1;
                idx_d      = cnt_q;
                valid_d    = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (valid_q && out_ready) begin
                    if (cnt_q == LastIdx) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        level_d    = rot_out;
                        level_load = 1'b1;
                        idx_d      = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Captured bank; written only on an accepted start.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FEATURES_PER_CC; i++) begin
                bank_q[i] <= '0;
            end
        end else if (load_bank) begin
            for (int i = 0; i < FEATURES_PER_CC; i++) begin
                bank_q[i] <= shifted_hv[i];
            end
        end
    end

`ifdef DEC_UNBIND_POPCOUNT_EN
    localparam int unsigned WeightW = $clog2(HV_DIM + 1);
    logic [WeightW-1:0] weight_q, weight_d;

    // Popcount of the rotator output, captured together with level_hv.
    always_comb begin
        weight_d = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            weight_d = weight_d + WeightW'(rot_out[i]);
        end
    end

    // Weight register tracks level_q.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            weight_q <= '0;
        end else if (level_load) begin
            weight_q <= weight_d;
        end
    end

    assign hv_weight = weight_q;
`endif

    assign level_hv  = level_q;
    assign feat_idx  = idx_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Directed self-checking bench for dec_unbinder_seq (HV_DIM=16, 4 features, shifts {3,0,15,8}).
module tb_dec_unbinder_seq;

    localparam int unsigned W = 16;
    localparam int unsigned F = 4;
    localparam int unsigned SH [F] = '{3, 0, 15, 8};

    logic         clk;
    logic         nrst;
    logic         start_decoding;
    logic [W-1:0] shifted_hv [0:F-1];
    logic [W-1:0] level_hv;
    logic [1:0]   feat_idx;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;
`ifdef DEC_UNBIND_POPCOUNT_EN
    logic [4:0]   hv_weight;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dec_unbinder_seq #(
        .HV_DIM          (W),
        .FEATURES_PER_CC (F),
        .SHIFT_BASE      (310)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_decoding (start_decoding),
        .shifted_hv     (shifted_hv),
        .level_hv       (level_hv),
        .feat_idx       (feat_idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
`ifdef DEC_UNBIND_POPCOUNT_EN
        .hv_weight      (hv_weight),
`endif
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Binder model: shifted[j] = level[(j - s) mod W].
    function automatic logic [W-1:0] bind_hv(input logic [W-1:0] v, input int unsigned s);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) begin
            r[j] = v[(j + W - s) % W];
        end
        return r;
    endfunction

    task automatic check_out(input string tag, input logic [W-1:0] exp_hv, input int exp_idx);
        check({tag, "_level"}, 32'(level_hv), 32'(exp_hv));
        check({tag, "_idx"}, 32'(feat_idx), 32'(exp_idx));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
`ifdef DEC_UNBIND_POPCOUNT_EN
        check({tag, "_weight"}, 32'(hv_weight), 32'($countones(exp_hv)));
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_level"}, 32'(level_hv), 32'd0);
        check({tag, "_idx"}, 32'(feat_idx), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
`ifdef DEC_UNBIND_POPCOUNT_EN
        check({tag, "_weight"}, 32'(hv_weight), 32'd0);
`endif
    endtask

    logic [W-1:0] orig [F];

    initial begin
        nrst           = 1'b0;
        start_decoding = 1'b0;
        out_ready      = 1'b1;
        for (int k = 0; k < F; k++) shifted_hv[k] = '0;
        #12;
        check_idle("reset");
        nrst = 1'b1;
        tick();

        // Basic unbind, out_ready held high.
        shifted_hv[0] = 16'h0008;
        shifted_hv[1] = 16'h1234;
        shifted_hv[2] = 16'h0001;
        shifted_hv[3] = 16'h0100;
        start_decoding = 1'b1;
        tick();
        start_decoding = 1'b0;
        check("basic_busy_load", 32'(busy), 32'd1);
        check("basic_valid_load", 32'(out_valid), 32'd0);
        tick();
        check_out("basic_f0", 16'h0001, 0);
        tick();
        check_out("basic_f1", 16'h1234, 1);
`ifdef DEC_UNBIND_POPCOUNT_EN
        check("basic_weight_1234", 32'(hv_weight), 32'd5);
`endif
        tick();
        check_out("basic_f2", 16'h0002, 2);
        tick();
        check_out("basic_f3", 16'h0001, 3);
        tick();
        check("basic_done", 32'(done), 32'd1);
        check("basic_done_busy", 32'(busy), 32'd1);
        check("basic_done_valid", 32'(out_valid), 32'd0);
        // A start coinciding with done must be ignored.
        start_decoding = 1'b1;
        tick();
        start_decoding = 1'b0;
        check("done_start_busy", 32'(busy), 32'd0);
        check("done_start_dpulse", 32'(done), 32'd0);
        tick();
        check("done_start_ignored", 32'(busy), 32'd0);

        // Wrap-around, ignored mid-pass start, backpressure on feature 2.
        shifted_hv[0] = 16'h0001;
        shifted_hv[1] = 16'hABCD;
        shifted_hv[2] = 16'h8000;
        shifted_hv[3] = 16'h00F0;
        start_decoding = 1'b1;
        tick();
        start_decoding = 1'b0;
        tick();
        check_out("wrap_f0", 16'h2000, 0);
        start_decoding = 1'b1;
        for (int k = 0; k < F; k++) shifted_hv[k] = 16'hFFFF;
        tick();
        start_decoding = 1'b0;
        check_out("ign_f1", 16'hABCD, 1);
        tick();
        check_out("bp_f2", 16'h0001, 2);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_out("bp_hold", 16'h0001, 2);
            check("bp_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_out("bp_f3", 16'hF000, 3);
        tick();
        check("bp_done", 32'(done), 32'd1);
        tick();
        check("bp_idle", 32'(busy), 32'd0);
        tick();
        check("no_second_pass", 32'(busy), 32'd0);
        check("no_second_valid", 32'(out_valid), 32'd0);

        // Reset mid-pass aborts at once.
        shifted_hv[0] = 16'h00FF;
        start_decoding = 1'b1;
        tick();
        start_decoding = 1'b0;
        tick();
        check_out("pre_rst_f0", 16'hE01F, 0);
        #2;
        nrst = 1'b0;
        #1;
        check_idle("mid_rst");
        #3;
        nrst = 1'b1;
        tick();
        check_idle("post_rst");

        // Round trip through the binder model.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < F; k++) begin
                orig[k]       = 16'($urandom);
                shifted_hv[k] = bind_hv(orig[k], SH[k]);
            end
            start_decoding = 1'b1;
            tick();
            start_decoding = 1'b0;
            tick();
            for (int k = 0; k < F; k++) begin
                check_out("rt", orig[k], k);
                tick();
            end
            check("rt_done", 32'(done), 32'd1);
            tick();
            check("rt_idle", 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
